// File: rtl/exu_bp_upd_q_pkg.sv
// Shared types for the EXU branch-predictor update path.
package veer_types;

    localparam int BP_UPD_DEPTH_MAX = 16;

    typedef struct packed {
        logic        misp;
        logic        ataken;
        logic [1:0]  hist;
        logic        way;
        logic        pcall;
        logic        pret;
        logic        pja;
        logic [31:1] pc;
        logic [31:1] target;
    } bp_upd_pkt_t;

endpackage

// File: rtl/exu_bp_upd_stats.sv
// Push / mispredict / drop event counters for the branch-predictor update queue.
module exu_bp_upd_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        push_misp,
    input  logic        drop,
    output logic [31:0] stat_push,
    output logic [31:0] stat_misp,
    output logic [31:0] stat_drop
);

    // Free-running wrap-around counters; only rst clears them, never a queue flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_push <= 32'd0;
            stat_misp <= 32'd0;
            stat_drop <= 32'd0;
        end else begin
            if (push) begin
                stat_push <= stat_push + 32'd1;
            end
            if (push_misp) begin
                stat_misp <= stat_misp + 32'd1;
            end
            if (drop) begin
                stat_drop <= stat_drop + 32'd1;
            end
        end
    end

endmodule

// File: rtl/exu_bp_upd_q.sv
// In-order FIFO between EXU branch resolution and the IFU BHT/BTB write port.
// Optional event counters are built when EXU_BP_STATS_EN is defined.
module exu_bp_upd_q
    import veer_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  bp_upd_pkt_t in_pkt,
    input  logic        clear,
    output logic        upd_valid,
    output bp_upd_pkt_t upd_pkt,
    input  logic        upd_ready,
    output logic        drop,
    output logic        q_empty,
    output logic        q_full
`ifdef EXU_BP_STATS_EN
    ,
    output logic [31:0] stat_push,
    output logic [31:0] stat_misp,
    output logic [31:0] stat_drop
`endif
);

    localparam int PTRW = $clog2(DEPTH);
    localparam logic [PTRW:0] PTR_ONE = (PTRW+1)'(1);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTRW:0]  wr_ptr_r;
    logic [PTRW:0]  rd_ptr_r;
    bp_upd_pkt_t    entry_r [DEPTH];
    logic [DEPTH-1:0] we_s;
    logic           empty_s;
    logic           full_s;
    logic           pop_s;
    logic           push_s;
    logic           drop_s;

    // Queue status and handshake qualification; clear suppresses both push and pop.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[PTRW-1:0] == rd_ptr_r[PTRW-1:0]) &&
                  (wr_ptr_r[PTRW] != rd_ptr_r[PTRW]);
        pop_s   = ~empty_s & upd_ready & ~clear;
        push_s  = in_valid & (~full_s | pop_s) & ~clear;
        drop_s  = in_valid & full_s & ~pop_s & ~clear;
        we_s    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (push_s && (wr_ptr_r[PTRW-1:0] == PTRW'(i))) begin
                we_s[i] = 1'b1;
            end else begin
                we_s[i] = 1'b0;
            end
        end
    end

    // Read/write pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Enabled entry storage; reset to zero so the head reads all zeros out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we_s[i]) begin
                    entry_r[i] <= in_pkt;
                end
            end
        end
    end

    assign upd_valid = ~empty_s;
    assign upd_pkt   = entry_r[rd_ptr_r[PTRW-1:0]];
    assign q_empty   = empty_s;
    assign q_full    = full_s;
    assign drop      = drop_s;

`ifdef EXU_BP_STATS_EN
    exu_bp_upd_stats u_stats (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_misp (push_s & in_pkt.misp),
        .drop      (drop_s),
        .stat_push (stat_push),
        .stat_misp (stat_misp),
        .stat_drop (stat_drop)
    );
`endif

endmodule

// File: tb/tb_exu_bp_upd_q.sv
// Randomised bench for exu_bp_upd_q against a queue-based reference model.
module tb_exu_bp_upd_q;
    import veer_types::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    bp_upd_pkt_t in_pkt;
    logic        clear;
    logic        upd_valid;
    bp_upd_pkt_t upd_pkt;
    logic        upd_ready;
    logic        drop;
    logic        q_empty;
    logic        q_full;
`ifdef EXU_BP_STATS_EN
    logic [31:0] stat_push;
    logic [31:0] stat_misp;
    logic [31:0] stat_drop;
`endif

    exu_bp_upd_q #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pkt    (in_pkt),
        .clear     (clear),
        .upd_valid (upd_valid),
        .upd_pkt   (upd_pkt),
        .upd_ready (upd_ready),
        .drop      (drop),
        .q_empty   (q_empty),
        .q_full    (q_full)
`ifdef EXU_BP_STATS_EN
        ,
        .stat_push (stat_push),
        .stat_misp (stat_misp),
        .stat_drop (stat_drop)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    bp_upd_pkt_t mq[$];
    int m_push = 0;
    int m_misp = 0;
    int m_drop = 0;

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bp_upd_pkt_t rnd_pkt();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return bp_upd_pkt_t'(r[69:0]);
    endfunction

    function automatic bp_upd_pkt_t pc_pkt(input logic [31:0] pc);
        bp_upd_pkt_t p;
        p = rnd_pkt();
        p.pc = pc[31:1];
        return p;
    endfunction

    task automatic chk_stats();
`ifdef EXU_BP_STATS_EN
        chk("stat_push", 70'(stat_push), 70'(m_push));
        chk("stat_misp", 70'(stat_misp), 70'(m_misp));
        chk("stat_drop", 70'(stat_drop), 70'(m_drop));
`endif
    endtask

    // One clock: drive, check outputs mid-cycle against the model, advance model and DUT.
    task automatic cyc(input logic iv, input bp_upd_pkt_t p, input logic rdy, input logic clr);
        logic full_m, pop_m, push_m, drop_m;
        in_valid  = iv;
        in_pkt    = p;
        upd_ready = rdy;
        clear     = clr;
        @(negedge clk);
        full_m = (mq.size() == DEPTH);
        pop_m  = (mq.size() != 0) && rdy && !clr;
        push_m = iv && (!full_m || pop_m) && !clr;
        drop_m = iv && full_m && !pop_m && !clr;
        chk("upd_valid", 70'(upd_valid), 70'(mq.size() != 0));
        chk("q_empty",   70'(q_empty),   70'(mq.size() == 0));
        chk("q_full",    70'(q_full),    70'(full_m));
        chk("drop",      70'(drop),      70'(drop_m));
        if (mq.size() != 0) begin
            chk("upd_pkt", upd_pkt, mq[0]);
        end
        chk_stats();
        if (clr) begin
            mq.delete();
        end else begin
            if (pop_m) void'(mq.pop_front());
            if (push_m) mq.push_back(p);
        end
        if (push_m) begin
            m_push++;
            if (p.misp) m_misp++;
        end
        if (drop_m) m_drop++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        chk("rst_upd_valid", 70'(upd_valid), 70'(0));
        chk("rst_q_empty",   70'(q_empty),   70'(1));
        chk("rst_q_full",    70'(q_full),    70'(0));
        chk("rst_drop",      70'(drop),      70'(0));
        chk("rst_upd_pkt",   upd_pkt,        70'(0));
        chk_stats();
    endtask

    bp_upd_pkt_t z;

    initial begin
        z = '0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_pkt = '0;
        clear = 1'b0;
        upd_ready = 1'b0;
        #12;
        chk_reset_state();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single push, immediate drain.
        cyc(1'b1, pc_pkt(32'h100), 1'b1, 1'b0);
        cyc(1'b0, z, 1'b1, 1'b0);
        cyc(1'b0, z, 1'b1, 1'b0);

        // Fill with ready low, then a fifth packet drops.
        for (int i = 0; i < 4; i++) cyc(1'b1, rnd_pkt(), 1'b0, 1'b0);
        cyc(1'b1, rnd_pkt(), 1'b0, 1'b0);

        // Full with simultaneous pop: accepted, no drop.
        cyc(1'b1, rnd_pkt(), 1'b1, 1'b0);
        cyc(1'b1, rnd_pkt(), 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, z, 1'b1, 1'b0);

        // Ten packets with alternating ready exercise pointer wrap.
        for (int i = 0; i < 10; i++) cyc(1'b1, rnd_pkt(), 1'(i % 2), 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, z, 1'b1, 1'b0);

        // Clear with three entries and a concurrent in_valid.
        for (int i = 0; i < 3; i++) cyc(1'b1, rnd_pkt(), 1'b0, 1'b0);
        cyc(1'b1, rnd_pkt(), 1'b1, 1'b1);
        cyc(1'b0, z, 1'b0, 1'b0);

        // Reset in the middle of a drain.
        for (int i = 0; i < 3; i++) cyc(1'b1, rnd_pkt(), 1'b0, 1'b0);
        cyc(1'b0, z, 1'b1, 1'b0);
        in_valid = 1'b0;
        upd_ready = 1'b0;
        clear = 1'b0;
        rst = 1'b1;
        #1;
        mq.delete();
        m_push = 0;
        m_misp = 0;
        m_drop = 0;
        chk_reset_state();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            cyc(1'($urandom_range(0, 99) < 60), rnd_pkt(),
                1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
